// File: rtl/imem_arbiter.sv
// imem_arbiter
//
// Shares the four-lane AT28C256 instruction-memory bank between the IF-stage
// fetch port and a byte-wide loader port. It also sequences the EEPROM
// CE/OE/WE strobes for reads and for byte writes, including the internal
// write-recovery time.
//
// Parameters
//   WR_PULSE_CYC : cycles mem_we_n is held low per byte write (>= 1)
//   WR_WAIT_CYC  : cycles of EEPROM internal write time after the pulse (>= 1)
//
// Ports
//   clk, rst                 : clock, synchronous active-low reset
//   f_req, f_addr            : fetch request / byte address ([14:2] used)
//   f_gnt, f_valid, f_data   : fetch accepted pulse, data-valid pulse, fetched word
//   l_req, l_addr, l_data    : loader write request / byte address / byte
//   l_gnt, l_done            : write accepted pulse, write fully complete pulse
//   busy                     : high whenever the sequencer is not idle
//   mem_addr                 : shared 13-bit word address to all four chips
//   mem_ce_n/oe_n/we_n       : per-lane active-low strobes
//   mem_wdata, mem_rdata     : write byte bus, 32-bit read bus (lane i = byte i)

module imem_arbiter #(
    parameter int WR_PULSE_CYC = 2,
    parameter int WR_WAIT_CYC  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic        f_valid,
    output logic [31:0] f_data,
    input  logic        l_req,
    input  logic [31:0] l_addr,
    input  logic [7:0]  l_data,
    output logic        l_gnt,
    output logic        l_done,
    output logic        busy,
    output logic [12:0] mem_addr,
    output logic [3:0]  mem_ce_n,
    output logic [3:0]  mem_oe_n,
    output logic [3:0]  mem_we_n,
    output logic [7:0]  mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_MAX = (WR_PULSE_CYC > WR_WAIT_CYC) ? WR_PULSE_CYC : WR_WAIT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // The counter is loaded with N-1 so that a phase lasts exactly N cycles
    // including the cycle in which the counter reads zero.
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(WR_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(WR_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WR_SETUP,
        WR_PULSE,
        WR_WAIT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last_fetch;   // 1 when the most recent grant went to fetch
    logic [3:0]       lane_mask;    // one-hot lane of the write in progress
    logic [3:0]       l_lane_mask;
    logic             pick_fetch;

    // Address bits outside the 32 KiB bank and the fetch byte offset are ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{f_addr[31:15], f_addr[1:0], l_addr[31:15]};

    assign l_lane_mask = 4'b0001 << l_addr[1:0];

    // Fetch wins when it is the only requester, or on a tie when the loader
    // held the previous grant.
    assign pick_fetch = f_req && (!l_req || !last_fetch);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_fetch <= 1'b0;
            lane_mask  <= 4'h0;
            f_gnt      <= 1'b0;
            f_valid    <= 1'b0;
            l_gnt      <= 1'b0;
            l_done     <= 1'b0;
            busy       <= 1'b0;
            f_data     <= 32'h0;
            mem_addr   <= 13'h0;
            mem_wdata  <= 8'h0;
            mem_ce_n   <= 4'hF;
            mem_oe_n   <= 4'hF;
            mem_we_n   <= 4'hF;
        end else begin
            f_gnt   <= 1'b0;
            f_valid <= 1'b0;
            l_gnt   <= 1'b0;
            l_done  <= 1'b0;

            case (state)
                IDLE: begin
                    if (pick_fetch) begin
                        state      <= FETCH;
                        f_gnt      <= 1'b1;
                        busy       <= 1'b1;
                        last_fetch <= 1'b1;
                        mem_addr   <= f_addr[14:2];
                        mem_ce_n   <= 4'h0;
                        mem_oe_n   <= 4'h0;
                    end else if (l_req) begin
                        state      <= WR_SETUP;
                        l_gnt      <= 1'b1;
                        busy       <= 1'b1;
                        last_fetch <= 1'b0;
                        mem_addr   <= l_addr[14:2];
                        mem_wdata  <= l_data;
                        lane_mask  <= l_lane_mask;
                        mem_ce_n   <= ~l_lane_mask;
                    end
                end

                FETCH: begin
                    f_data   <= mem_rdata;
                    f_valid  <= 1'b1;
                    mem_ce_n <= 4'hF;
                    mem_oe_n <= 4'hF;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end

                WR_SETUP: begin
                    // CE has been stable for a cycle; now assert WE on the same lane.
                    mem_we_n <= ~lane_mask;
                    cnt      <= PULSE_LOAD;
                    state    <= WR_PULSE;
                end

                WR_PULSE: begin
                    if (cnt == '0) begin
                        mem_we_n <= 4'hF;
                        mem_ce_n <= 4'hF;
                        cnt      <= WAIT_LOAD;
                        state    <= WR_WAIT;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                WR_WAIT: begin
                    // Address and data stay put while the chip completes its
                    // internal write cycle.
                    if (cnt == '0) begin
                        l_done <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    mem_ce_n <= 4'hF;
                    mem_oe_n <= 4'hF;
                    mem_we_n <= 4'hF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
module tb_imem_arbiter;

    localparam int P = 2;
    localparam int W = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        f_req = 1'b0;
    logic [31:0] f_addr = 32'h0;
    logic        f_gnt;
    logic        f_valid;
    logic [31:0] f_data;
    logic        l_req = 1'b0;
    logic [31:0] l_addr = 32'h0;
    logic [7:0]  l_data = 8'h0;
    logic        l_gnt;
    logic        l_done;
    logic        busy;
    logic [12:0] mem_addr;
    logic [3:0]  mem_ce_n;
    logic [3:0]  mem_oe_n;
    logic [3:0]  mem_we_n;
    logic [7:0]  mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    int   passed = 0;
    int   total  = 0;
    int   viol   = 0;
    logic model_last_fetch = 1'b0;   // reference arbiter state: last grant was fetch

    imem_arbiter #(.WR_PULSE_CYC(P), .WR_WAIT_CYC(W)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid), .f_data(f_data),
        .l_req(l_req), .l_addr(l_addr), .l_data(l_data), .l_gnt(l_gnt), .l_done(l_done),
        .busy(busy), .mem_addr(mem_addr), .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n),
        .mem_we_n(mem_we_n), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Strobe exclusivity: no lane with WE and OE both low, at most one WE low.
    logic [3:0] we_low;
    logic [3:0] oe_low;
    assign we_low = ~mem_we_n;
    assign oe_low = ~mem_oe_n;
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if ((we_low & oe_low) != 4'h0 || $countones(we_low) > 1)
                viol <= viol + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst   = 1'b0;
        f_req = 1'b0;
        l_req = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        model_last_fetch = 1'b0;
    endtask

    task automatic test_reset;
        rst   = 1'b0;
        f_req = 1'b0;
        l_req = 1'b0;
        tick;
        tick;
        total++;
        if ({f_gnt, f_valid, l_gnt, l_done, busy} !== 5'b0)
            $display("FAIL reset_pulses: got %b expected 00000", {f_gnt, f_valid, l_gnt, l_done, busy});
        else passed++;
        total++;
        if (f_data !== 32'h0 || mem_addr !== 13'h0 || mem_wdata !== 8'h0)
            $display("FAIL reset_data: got f_data=%h mem_addr=%h wdata=%h expected all 0", f_data, mem_addr, mem_wdata);
        else passed++;
        total++;
        if ({mem_ce_n, mem_oe_n, mem_we_n} !== 12'hFFF)
            $display("FAIL reset_strobes: got %h expected fff", {mem_ce_n, mem_oe_n, mem_we_n});
        else passed++;
        rst = 1'b1;
        model_last_fetch = 1'b0;
        tick;
        total++;
        if (busy !== 1'b0)
            $display("FAIL reset_idle_busy: got %b expected 0", busy);
        else passed++;
    endtask

    task automatic test_single_fetch;
        f_addr    = 32'h0000_0104;
        mem_rdata = 32'h0050_0093;
        f_req     = 1'b1;
        tick;
        total++;
        if (f_gnt !== 1'b1 || mem_addr !== 13'h041 || mem_ce_n !== 4'h0 || mem_oe_n !== 4'h0 || busy !== 1'b1)
            $display("FAIL fetch_grant: got gnt=%b addr=%h ce=%h oe=%h busy=%b expected 1 041 0 0 1",
                     f_gnt, mem_addr, mem_ce_n, mem_oe_n, busy);
        else passed++;
        f_req = 1'b0;
        tick;
        total++;
        if (f_valid !== 1'b1 || f_gnt !== 1'b0 || f_data !== 32'h0050_0093)
            $display("FAIL fetch_valid: got valid=%b gnt=%b data=%h expected 1 0 00500093", f_valid, f_gnt, f_data);
        else passed++;
        total++;
        if (mem_ce_n !== 4'hF || mem_oe_n !== 4'hF || busy !== 1'b0)
            $display("FAIL fetch_release: got ce=%h oe=%h busy=%b expected f f 0", mem_ce_n, mem_oe_n, busy);
        else passed++;
        mem_rdata = 32'hDEAD_BEEF;
        tick;
        total++;
        if (f_valid !== 1'b0 || f_data !== 32'h0050_0093)
            $display("FAIL fetch_hold: got valid=%b data=%h expected 0 00500093", f_valid, f_data);
        else passed++;
        model_last_fetch = 1'b1;
    endtask

    task automatic test_write;
        int   done_n;
        int   we_cnt;
        int   we_first;
        int   we_bad;
        logic got;
        l_addr = 32'h0000_0206;
        l_data = 8'hA5;
        l_req  = 1'b1;
        tick;
        total++;
        if (l_gnt !== 1'b1 || mem_ce_n !== 4'b1011 || mem_addr !== 13'h081 || mem_wdata !== 8'hA5
            || mem_we_n !== 4'hF || mem_oe_n !== 4'hF)
            $display("FAIL write_setup: got gnt=%b ce=%b addr=%h wdata=%h we=%b oe=%b expected 1 1011 081 a5 1111 1111",
                     l_gnt, mem_ce_n, mem_addr, mem_wdata, mem_we_n, mem_oe_n);
        else passed++;
        l_req = 1'b0;
        got = 1'b0; done_n = -1; we_cnt = 0; we_first = -1; we_bad = 0;
        for (int n = 1; n <= 40 && !got; n++) begin
            tick;
            if (mem_we_n !== 4'hF) begin
                we_cnt++;
                if (we_first < 0) we_first = n;
                if (mem_we_n !== 4'b1011) we_bad++;
            end
            if (l_done === 1'b1) begin
                got    = 1'b1;
                done_n = n;
            end
        end
        total++;
        if (done_n !== 1 + P + W)
            $display("FAIL write_done_latency: got %0d expected %0d", done_n, 1 + P + W);
        else passed++;
        total++;
        if (we_cnt !== P || we_first !== 1 || we_bad !== 0)
            $display("FAIL write_pulse: got cycles=%0d first=%0d bad=%0d expected %0d 1 0", we_cnt, we_first, we_bad, P);
        else passed++;
        total++;
        if (busy !== 1'b0 || mem_ce_n !== 4'hF || mem_addr !== 13'h081 || mem_wdata !== 8'hA5)
            $display("FAIL write_end: got busy=%b ce=%h addr=%h wdata=%h expected 0 f 081 a5", busy, mem_ce_n, mem_addr, mem_wdata);
        else passed++;
        model_last_fetch = 1'b0;
    endtask

    task automatic test_contention;
        logic got;
        do_reset;
        f_addr = 32'h0000_0010; mem_rdata = 32'h1122_3344;
        l_addr = 32'h0000_0021; l_data = 8'h3C;
        f_req = 1'b1; l_req = 1'b1;
        tick;
        total++;
        if ({f_gnt, l_gnt} !== 2'b10)
            $display("FAIL tie_first: got f_gnt,l_gnt=%b expected 10", {f_gnt, l_gnt});
        else passed++;
        f_req = 1'b0;
        tick;
        tick;
        total++;
        if (l_gnt !== 1'b1 || mem_ce_n !== 4'b1101)
            $display("FAIL tie_second: got l_gnt=%b ce=%b expected 1 1101", l_gnt, mem_ce_n);
        else passed++;
        l_req = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 30 && !got; n++) begin
            tick;
            if (l_done === 1'b1) got = 1'b1;
        end
        total++;
        if (got !== 1'b1)
            $display("FAIL tie_write_done: got %b expected 1", got);
        else passed++;
        f_req = 1'b1; l_req = 1'b1;
        tick;
        total++;
        if ({f_gnt, l_gnt} !== 2'b10)
            $display("FAIL tie_alternate: got f_gnt,l_gnt=%b expected 10", {f_gnt, l_gnt});
        else passed++;
        f_req = 1'b0;
        tick;
        tick;
        total++;
        if (l_gnt !== 1'b1)
            $display("FAIL tie_alternate_write: got %b expected 1", l_gnt);
        else passed++;
        l_req = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 30 && !got; n++) begin
            tick;
            if (l_done === 1'b1) got = 1'b1;
        end
        total++;
        if (got !== 1'b1)
            $display("FAIL tie_alternate_done: got %b expected 1", got);
        else passed++;
        model_last_fetch = 1'b0;
    endtask

    task automatic test_fetch_blocked;
        int   early;
        logic got;
        l_addr = 32'h0000_1003; l_data = 8'h5A; l_req = 1'b1;
        tick;
        l_req = 1'b0;
        for (int n = 1; n <= 5; n++) tick;
        f_addr = 32'h0000_0040; mem_rdata = 32'hCAFE_F00D; f_req = 1'b1;
        early = 0; got = 1'b0;
        for (int n = 0; n < 30 && !got; n++) begin
            tick;
            if (f_gnt === 1'b1) early++;
            if (l_done === 1'b1) got = 1'b1;
        end
        total++;
        if (early !== 0 || got !== 1'b1)
            $display("FAIL blocked_during_write: got early_gnts=%0d done=%b expected 0 1", early, got);
        else passed++;
        tick;
        total++;
        if (f_gnt !== 1'b1 || mem_addr !== 13'h010)
            $display("FAIL blocked_grant_after: got gnt=%b addr=%h expected 1 010", f_gnt, mem_addr);
        else passed++;
        f_req = 1'b0;
        tick;
        total++;
        if (f_valid !== 1'b1 || f_data !== 32'hCAFE_F00D)
            $display("FAIL blocked_fetch_data: got valid=%b data=%h expected 1 cafef00d", f_valid, f_data);
        else passed++;
        model_last_fetch = 1'b1;
    endtask

    task automatic test_reset_mid_write;
        int dones;
        l_addr = 32'h0000_0002; l_data = 8'h77; l_req = 1'b1;
        tick;
        l_req = 1'b0;
        tick;
        total++;
        if (mem_we_n !== 4'b1011)
            $display("FAIL midreset_pulse_active: got we=%b expected 1011", mem_we_n);
        else passed++;
        rst = 1'b0;
        tick;
        total++;
        if (mem_we_n !== 4'hF || mem_ce_n !== 4'hF || busy !== 1'b0 || l_done !== 1'b0)
            $display("FAIL midreset_abandon: got we=%h ce=%h busy=%b done=%b expected f f 0 0",
                     mem_we_n, mem_ce_n, busy, l_done);
        else passed++;
        rst = 1'b1;
        model_last_fetch = 1'b0;
        dones = 0;
        for (int n = 0; n < 25; n++) begin
            tick;
            if (l_done === 1'b1 || busy === 1'b1) dones++;
        end
        total++;
        if (dones !== 0)
            $display("FAIL midreset_no_done: got %0d activity cycles expected 0", dones);
        else passed++;
    endtask

    task automatic test_random;
        int         kind;
        int         fg;
        int         lg;
        int         we_cnt;
        logic       wf;
        logic       wl;
        logic       fdone;
        logic       ldone;
        logic       first_set;
        logic       first_fetch;
        logic       exp_first_fetch;
        logic [31:0] fa;
        logic [31:0] la;
        logic [31:0] rd;
        logic [7:0]  ld;
        logic [3:0]  exp_ce;
        do_reset;
        for (int it = 0; it < 150; it++) begin
            kind = int'($urandom_range(0, 2));
            wf = (kind != 1);
            wl = (kind != 0);
            fa = $urandom; la = $urandom; rd = $urandom; ld = 8'($urandom);
            exp_ce = ~(4'b0001 << la[1:0]);
            f_addr = fa; l_addr = la; l_data = ld; mem_rdata = rd;
            f_req = wf; l_req = wl;
            exp_first_fetch = wf && (!wl || !model_last_fetch);
            first_fetch = ~exp_first_fetch;
            first_set = 1'b0;
            fdone = !wf; ldone = !wl;
            fg = -100; lg = -100; we_cnt = 0;
            for (int c = 0; c < 60 && !(fdone && ldone); c++) begin
                tick;
                if (f_gnt === 1'b1) begin
                    if (!first_set) begin first_set = 1'b1; first_fetch = 1'b1; end
                    f_req = 1'b0; fg = c; model_last_fetch = 1'b1;
                    total++;
                    if (mem_addr !== fa[14:2] || mem_oe_n !== 4'h0)
                        $display("FAIL rnd_fetch_addr it=%0d: got addr=%h oe=%h expected %h 0", it, mem_addr, mem_oe_n, fa[14:2]);
                    else passed++;
                end
                if (l_gnt === 1'b1) begin
                    if (!first_set) begin first_set = 1'b1; first_fetch = 1'b0; end
                    l_req = 1'b0; lg = c; model_last_fetch = 1'b0;
                    total++;
                    if (mem_addr !== la[14:2] || mem_ce_n !== exp_ce || mem_wdata !== ld)
                        $display("FAIL rnd_write_setup it=%0d: got addr=%h ce=%b wdata=%h expected %h %b %h",
                                 it, mem_addr, mem_ce_n, mem_wdata, la[14:2], exp_ce, ld);
                    else passed++;
                end
                if (mem_we_n !== 4'hF) we_cnt++;
                if (f_valid === 1'b1) begin
                    fdone = 1'b1;
                    total++;
                    if (c !== fg + 1 || f_data !== rd)
                        $display("FAIL rnd_fetch_data it=%0d: got cyc=%0d data=%h expected cyc=%0d data=%h", it, c, f_data, fg + 1, rd);
                    else passed++;
                end
                if (l_done === 1'b1) begin
                    ldone = 1'b1;
                    total++;
                    if (c !== lg + 1 + P + W || we_cnt !== P)
                        $display("FAIL rnd_write_done it=%0d: got cyc=%0d we_cycles=%0d expected cyc=%0d we_cycles=%0d",
                                 it, c, we_cnt, lg + 1 + P + W, P);
                    else passed++;
                end
            end
            total++;
            if (!(fdone && ldone))
                $display("FAIL rnd_timeout it=%0d: got fetch_done=%b write_done=%b expected 1 1", it, fdone, ldone);
            else passed++;
            total++;
            if (first_fetch !== exp_first_fetch)
                $display("FAIL rnd_order it=%0d: got first_fetch=%b expected %b", it, first_fetch, exp_first_fetch);
            else passed++;
        end
        f_req = 1'b0;
        l_req = 1'b0;
        tick;
        total++;
        if (viol !== 0)
            $display("FAIL strobe_exclusive: got %0d violating cycles expected 0", viol);
        else passed++;
    endtask

    initial begin
        test_reset;
        test_single_fetch;
        test_write;
        test_contention;
        test_fetch_blocked;
        test_reset_mid_write;
        test_random;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
